// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling permutation stage: walks i over 0..255, accumulates j and
// swaps s[i]/s[j] in the shared RAM, then holds done for the decrypt stage.
module ksa_swap_fsm #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [7:0]             mem_addr,
  output logic [7:0]             mem_data,
  output logic                   mem_wren,
  input  logic [7:0]             mem_q,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, DONE
  } state_t;

  localparam logic [3:0] K_LAST = 4'(KEY_BYTES - 1);

  state_t     state;
  logic [7:0] i, j, si, sj;
  logic [3:0] k;
  logic [7:0] key_byte;
  logic [7:0] j_next;

  // Key byte 0 sits in the most significant byte of secret_key.
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++)
      if (k == 4'(n)) key_byte = secret_key[8*(KEY_BYTES-1-n) +: 8];
  end

  assign j_next = j + mem_q + key_byte;

  // Write data is a pure mux of captured registers, so mem_q never reaches an output.
  assign mem_data = (state == WR_J) ? si : sj;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      mem_addr <= '0;
      mem_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            mem_addr <= '0;
            mem_wren <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= RD_I;
          end
        end
        RD_I: state <= WT_I;
        WT_I: begin
          si       <= mem_q;
          j        <= j_next;
          mem_addr <= j_next;
          state    <= RD_J;
        end
        RD_J: state <= WT_J;
        WT_J: begin
          sj       <= mem_q;
          mem_addr <= i;
          mem_wren <= 1'b1;
          state    <= WR_I;
        end
        WR_I: begin
          mem_addr <= j;
          state    <= WR_J;
        end
        WR_J: begin
          mem_wren <= 1'b0;
          if (i == 8'hFF) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i        <= i + 8'd1;
            k        <= (k == K_LAST) ? 4'd0 : k + 4'd1;
            mem_addr <= i + 8'd1;
            state    <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Bench for ksa_swap_fsm: RAM models with registered address, an expected-write
// scoreboard per instance, and a behavioural RC4 KSA model for final contents.
module tb_ksa_swap_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start0, start1, fill;
  logic [23:0] key0;
  logic [7:0]  key1;
  logic [7:0]  addr0, data0, q0, addr1, data1, q1;
  logic        wren0, busy0, done0, wren1, busy1, done1;

  ksa_swap_fsm #(.KEY_BYTES(3)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .secret_key(key0),
    .mem_addr(addr0), .mem_data(data0), .mem_wren(wren0), .mem_q(q0),
    .busy(busy0), .done(done0)
  );

  ksa_swap_fsm #(.KEY_BYTES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .secret_key(key1),
    .mem_addr(addr1), .mem_data(data1), .mem_wren(wren1), .mem_q(q1),
    .busy(busy1), .done(done1)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] q_exp0[$];
  logic [15:0] q_exp1[$];
  logic [7:0]  exp_s[256];
  logic [7:0]  ram0[256];
  logic [7:0]  ram1[256];
  logic [7:0]  ar0, ar1;
  bit          have_last[2];
  bit          phase[2];
  int          last_wr[2];

  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: address registered inside the RAM, write on the clock edge.
  always @(posedge clk) begin
    if (fill) begin
      for (int n = 0; n < 256; n++) begin
        ram0[n] <= n[7:0];
        ram1[n] <= n[7:0];
      end
    end else begin
      if (wren0) ram0[addr0] <= data0;
      if (wren1) ram1[addr1] <= data1;
    end
    ar0 <= addr0;
    ar1 <= addr1;
  end
  assign q0 = ram0[ar0];
  assign q1 = ram1[ar1];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic on_write(input int inst, input logic [7:0] a, input logic [7:0] d);
    logic [15:0] e;
    int sz;
    sz = (inst == 0) ? q_exp0.size() : q_exp1.size();
    if (sz == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_write inst%0d: got addr %0d data %0d, required no write",
               inst, a, d);
    end else begin
      if (inst == 0) e = q_exp0.pop_front();
      else           e = q_exp1.pop_front();
      chk("wr_addr", int'(a), int'(e[15:8]));
      chk("wr_data", int'(d), int'(e[7:0]));
    end
    if (have_last[inst]) chk("wr_gap", cyc - last_wr[inst], phase[inst] ? 1 : 5);
    have_last[inst] = 1'b1;
    last_wr[inst]   = cyc;
    phase[inst]     = ~phase[inst];
  endtask

  // Scoreboard monitors: compare every presented write against the queue.
  always @(negedge clk) begin
    if (reset || !busy0) begin have_last[0] = 1'b0; phase[0] = 1'b0; end
    if (wren0) on_write(0, addr0, data0);
    if (reset || !busy1) begin have_last[1] = 1'b0; phase[1] = 1'b0; end
    if (wren1) on_write(1, addr1, data1);
  end

  // Behavioural RC4 KSA from an identity table; queues the expected write stream.
  task automatic model(input logic [127:0] key, input int kb, input int inst);
    logic [7:0] s[256];
    logic [7:0] j, t, kbyte;
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kbyte = 8'(key >> (8 * (kb - 1 - (i % kb))));
      j = j + s[i] + kbyte;
      if (inst == 0) begin
        q_exp0.push_back({8'(i), s[j]});
        q_exp0.push_back({j, s[i]});
      end else begin
        q_exp1.push_back({8'(i), s[j]});
        q_exp1.push_back({j, s[i]});
      end
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    exp_s = s;
  endtask

  task automatic refill();
    @(posedge clk); #2 fill = 1'b1;
    @(posedge clk); #2 fill = 1'b0;
  endtask

  task automatic run(input int inst, input bit extra, output int cycles);
    @(posedge clk); #2;
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #2;
    start0 = 1'b0; start1 = 1'b0;
    chk("busy_after_start", int'(inst == 0 ? busy0 : busy1), 1);
    chk("done_cleared_on_start", int'(inst == 0 ? done0 : done1), 0);
    cycles = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #2;
      if (inst == 0) start0 = extra && (n == 10 || n == 700);
      if ((inst == 0) ? done0 : done1) begin cycles = n; break; end
    end
    start0 = 1'b0;
    chk("busy_low_at_done", int'(inst == 0 ? busy0 : busy1), 0);
  endtask

  task automatic check_final(input int inst);
    bit   seen[256];
    int   bad, distinct;
    logic [7:0] v;
    bad = 0; distinct = 0;
    for (int n = 0; n < 256; n++) begin
      v = (inst == 0) ? ram0[n] : ram1[n];
      if (v !== exp_s[n]) bad++;
      if (!seen[v]) distinct++;
      seen[v] = 1'b1;
    end
    chk("final_ram_mismatches", bad, 0);
    chk("permutation_distinct", distinct, 256);
    chk("pending_writes", (inst == 0) ? q_exp0.size() : q_exp1.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; fill = 1'b1;
    key0 = '0; key1 = '0;

    // Reset held with random inputs.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      start0 = 1'($urandom_range(0, 1));
      key0   = 24'($urandom);
      #1;
      chk("rst_busy", int'(busy0), 0);
      chk("rst_done", int'(done0), 0);
      chk("rst_wren", int'(wren0), 0);
      chk("rst_addr", int'(addr0), 0);
    end
    start0 = 1'b0; fill = 1'b0;
    @(posedge clk); #2 reset = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("idle_busy", int'(busy0), 0);
    chk("idle_done", int'(done0), 0);

    // Key 0: hand-traced first three iterations, then abort.
    key0 = 24'h000000;
    q_exp0.push_back({8'd0, 8'd0}); q_exp0.push_back({8'd0, 8'd0});
    q_exp0.push_back({8'd1, 8'd1}); q_exp0.push_back({8'd1, 8'd1});
    q_exp0.push_back({8'd2, 8'd3}); q_exp0.push_back({8'd3, 8'd2});
    @(posedge clk); #2 start0 = 1'b1;
    @(posedge clk); #2 start0 = 1'b0;
    repeat (18) @(posedge clk);
    #2;
    chk("key0_trace_remaining", q_exp0.size(), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Key 0x000249 full run.
    key0 = 24'h000249;
    refill();
    model(128'h000249, 3, 0);
    run(0, 1'b0, cycles);
    chk("done_latency", cycles, 1536);
    check_final(0);

    // Same key with stray start pulses mid-run.
    refill();
    model(128'h000249, 3, 0);
    run(0, 1'b1, cycles);
    chk("done_latency_extra_start", cycles, 1536);
    check_final(0);

    // Restart from DONE.
    refill();
    chk("done_held", int'(done0), 1);
    model(128'h000249, 3, 0);
    run(0, 1'b0, cycles);
    chk("done_latency_restart", cycles, 1536);
    check_final(0);

    // Abort during iteration 100 WR_I.
    refill();
    model(128'h000249, 3, 0);
    @(posedge clk); #2 start0 = 1'b1;
    @(posedge clk); #2 start0 = 1'b0;
    repeat (604) @(posedge clk);
    #2;
    chk("abort_wren_before", int'(wren0), 1);
    chk("abort_addr_before", int'(addr0), 100);
    reset = 1'b1;
    #1;
    chk("abort_wren_after", int'(wren0), 0);
    chk("abort_busy_after", int'(busy0), 0);
    chk("abort_addr_after", int'(addr0), 0);
    chk("abort_pending", q_exp0.size(), 312);
    q_exp0.delete();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    refill();
    model(128'h000249, 3, 0);
    run(0, 1'b0, cycles);
    chk("done_latency_after_abort", cycles, 1536);
    check_final(0);

    // Single-byte key.
    key1 = 8'h05;
    refill();
    model(128'h05, 1, 1);
    run(1, 1'b0, cycles);
    chk("done_latency_kb1", cycles, 1536);
    check_final(1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
